// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational ALU between two
// requesters. One operation in flight: grant in IDLE, let the ALU settle for
// one cycle in EXEC, then hold the captured result in RESP until it is taken.
module alu_share_arbiter #(
    parameter int W   = 4,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_opcode,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_opcode,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    output logic [OPW-1:0] alu_opcode,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic [W-1:0]   alu_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_result,
    output logic           rsp_id,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OPW-1:0] opcode;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
    } req_t;

    state_t       state, state_nxt;
    logic         rr_ptr;
    logic [1:0]   vld;
    req_t [1:0]   req;
    logic         gnt_vld;
    logic         gnt_id;

    assign vld    = {req1_valid, req0_valid};
    assign req[0] = {req0_opcode, req0_a, req0_b};
    assign req[1] = {req1_opcode, req1_a, req1_b};

    // Round-robin grant: the pointed-to requester wins, otherwise the other one.
    // Only evaluated in IDLE so ready is never raised while an op is in flight.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = rr_ptr;
        if (state == IDLE) begin
            if (vld[rr_ptr]) begin
                gnt_vld = 1'b1;
                gnt_id  = rr_ptr;
            end else if (vld[~rr_ptr]) begin
                gnt_vld = 1'b1;
                gnt_id  = ~rr_ptr;
            end
        end
    end

    assign req0_ready = gnt_vld && (gnt_id == 1'b0);
    assign req1_ready = gnt_vld && (gnt_id == 1'b1);
    assign busy       = (state != IDLE);

    // Next-state: grant -> one settle cycle -> hold response until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath: latch the winner onto the ALU, capture its result, hand it back.
    // The pointer moves only on a grant, so an idle requester keeps its turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            rsp_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        {alu_opcode, alu_a, alu_b} <= req[gnt_id];
                        rsp_id <= gnt_id;
                        rr_ptr <= ~gnt_id;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_share_arbiter;

    localparam logic [3:0] ADD_OP = 4'd0;
    localparam logic [3:0] SUB_OP = 4'd1;
    localparam logic [3:0] AND_OP = 4'd2;
    localparam logic [3:0] OR_OP  = 4'd3;
    localparam logic [3:0] XOR_OP = 4'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_opcode, req0_a, req0_b;
    logic [3:0] req1_opcode, req1_a, req1_b;
    logic [3:0] alu_opcode, alu_a, alu_b, alu_result;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [3:0] rsp_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.W(4), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy)
    );

    // Stand-in combinational ALU; unknown opcodes give 0.
    function automatic logic [3:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            ADD_OP:  return a + b;
            SUB_OP:  return a - b;
            AND_OP:  return a & b;
            OR_OP:   return a | b;
            XOR_OP:  return a ^ b;
            4'd5:    return ~a;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_opcode, alu_a, alu_b);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs only change just after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // Model: an op is "in flight" from acceptance until its response is taken;
    // its result appears one cycle after acceptance and is held until consumed.
    bit         m_busy = 0;
    int         m_age  = 0;
    bit         m_ptr  = 0;
    bit         m_rv   = 0;
    bit         m_id   = 0;
    logic [3:0] m_res = 0, m_opc = 0, m_a = 0, m_b = 0;

    initial begin
        forever begin
            @(negedge clk);
            begin
                logic [1:0] v;
                bit         g_vld;
                bit         g;
                v     = {req1_valid, req0_valid};
                g_vld = 0;
                g     = 0;
                if (!m_busy) begin
                    if (v[m_ptr])       begin g_vld = 1; g = m_ptr;  end
                    else if (v[!m_ptr]) begin g_vld = 1; g = !m_ptr; end
                end
                check("m_req0_ready", int'(req0_ready), int'(g_vld && g == 0));
                check("m_req1_ready", int'(req1_ready), int'(g_vld && g == 1));
                check("m_busy",       int'(busy),       int'(m_busy));
                check("m_rsp_valid",  int'(rsp_valid),  int'(m_rv));
                check("m_rsp_result", int'(rsp_result), int'(m_res));
                check("m_rsp_id",     int'(rsp_id),     int'(m_id));
                check("m_alu_opcode", int'(alu_opcode), int'(m_opc));
                check("m_alu_a",      int'(alu_a),      int'(m_a));
                check("m_alu_b",      int'(alu_b),      int'(m_b));
                // advance to the state after the coming rising edge
                if (rst) begin
                    m_busy = 0; m_ptr = 0; m_rv = 0; m_id = 0;
                    m_res = 0; m_opc = 0; m_a = 0; m_b = 0;
                end else if (!m_busy) begin
                    if (g_vld) begin
                        m_opc  = g ? req1_opcode : req0_opcode;
                        m_a    = g ? req1_a : req0_a;
                        m_b    = g ? req1_b : req0_b;
                        m_id   = g;
                        m_ptr  = !g;
                        m_busy = 1;
                        m_age  = 1;
                    end
                end else if (m_age == 1) begin
                    m_res = alu_fn(m_opc, m_a, m_b);
                    m_rv  = 1;
                    m_age = 2;
                end else if (rsp_ready) begin
                    m_rv   = 0;
                    m_busy = 0;
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input int k, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, output int waited);
        tick();
        if (k == 0) begin req0_valid = 1; req0_opcode = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1; req1_opcode = op; req1_a = a; req1_b = b; end
        waited = 0;
        @(negedge clk);
        while (!(k == 0 ? req0_ready : req1_ready) && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 20) check("issue_timeout", waited, 0);
        tick();
        if (k == 0) req0_valid = 0;
        else        req1_valid = 0;
    endtask

    task automatic wait_rsp(input string name, input logic [3:0] exp_res, input bit exp_id);
        int n = 0;
        @(negedge clk);
        while (!(rsp_valid && rsp_ready) && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) check({name, "_timeout"}, n, 0);
        check({name, "_result"}, int'(rsp_result), int'(exp_res));
        check({name, "_id"},     int'(rsp_id),     int'(exp_id));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int w;
        rst = 1; rsp_ready = 0;
        req0_valid = 0; req0_opcode = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_opcode = 0; req1_a = 0; req1_b = 0;
        tick(); tick();
        rst = 0;

        // reset then idle
        @(negedge clk);
        check("rst_rsp_valid",  int'(rsp_valid),  0);
        check("rst_busy",       int'(busy),       0);
        check("rst_ready0",     int'(req0_ready), 0);
        check("rst_ready1",     int'(req1_ready), 0);
        check("rst_alu_a",      int'(alu_a),      0);
        check("rst_rsp_result", int'(rsp_result), 0);

        // single op with cycle-exact latency
        tick();
        req0_valid = 1; req0_opcode = ADD_OP; req0_a = 4'd3; req0_b = 4'd5; rsp_ready = 1;
        @(negedge clk);
        check("single_ready0", int'(req0_ready), 1);
        check("single_ready1", int'(req1_ready), 0);
        tick();
        req0_valid = 0;
        @(negedge clk);
        check("single_alu_a",      int'(alu_a),      3);
        check("single_alu_b",      int'(alu_b),      5);
        check("single_exec_rv",    int'(rsp_valid),  0);
        check("single_exec_busy",  int'(busy),       1);
        @(negedge clk);
        check("single_rv",     int'(rsp_valid),  1);
        check("single_result", int'(rsp_result), 8);
        check("single_id",     int'(rsp_id),     0);
        tick();
        @(negedge clk);
        check("single_done_rv",   int'(rsp_valid), 0);
        check("single_done_busy", int'(busy),      0);

        // contention from a fresh pointer
        tick(); rst = 1;
        tick(); rst = 0;
        req0_valid = 1; req0_opcode = SUB_OP; req0_a = 4'd9; req0_b = 4'd4;
        req1_valid = 1; req1_opcode = XOR_OP; req1_a = 4'hA; req1_b = 4'h6;
        wait_rsp("cont_first",  4'd5, 0);
        wait_rsp("cont_second", 4'hC, 1);
        wait_rsp("cont_third",  4'd5, 0);
        tick();
        req0_valid = 0; req1_valid = 0;

        // backpressure: response held for 5 cycles
        tick(); rsp_ready = 0;
        issue(0, OR_OP, 4'h5, 4'hA, w);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rv",     int'(rsp_valid),  1);
            check("bp_result", int'(rsp_result), 4'hF);
            check("bp_id",     int'(rsp_id),     0);
            check("bp_ready0", int'(req0_ready), 0);
            check("bp_ready1", int'(req1_ready), 0);
            check("bp_busy",   int'(busy),       1);
        end
        tick(); rsp_ready = 1;
        @(negedge clk);
        check("bp_release_rv", int'(rsp_valid), 1);
        tick();
        @(negedge clk);
        check("bp_after_rv",   int'(rsp_valid), 0);
        check("bp_after_busy", int'(busy),      0);

        // pointer hold: req1 alone is granted immediately, twice
        issue(1, AND_OP, 4'hF, 4'h3, w);
        wait_rsp("hold_first", 4'd3, 1);
        issue(1, AND_OP, 4'hF, 4'h3, w);
        check("hold_immediate", w, 0);
        wait_rsp("hold_second", 4'd3, 1);

        // reset while in EXEC: the op is dropped silently
        issue(0, ADD_OP, 4'd1, 4'd1, w);
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstmid_rv",   int'(rsp_valid), 0);
            check("rstmid_busy", int'(busy),      0);
        end

        // randomized traffic, all checked by the model
        for (int i = 0; i < 600; i++) begin
            tick();
            rst         = ($urandom_range(0, 63) == 0);
            req0_valid  = $urandom_range(0, 1) == 1;
            req1_valid  = $urandom_range(0, 1) == 1;
            req0_opcode = 4'($urandom_range(0, 15));
            req1_opcode = 4'($urandom_range(0, 15));
            req0_a      = 4'($urandom);
            req0_b      = 4'($urandom);
            req1_a      = 4'($urandom);
            req1_b      = 4'($urandom);
            rsp_ready   = $urandom_range(0, 9) < 7;
        end
        tick();
        rst = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
